// File: rtl/or1200_thread_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_thread_sched_pkg
//  Purpose  : Shared thread-state encodings and scheduler defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package or1200_thread_sched_pkg;

    localparam int c_OR1200_NTHREADS       = 8;
    localparam int c_OR1200_THREAD_WIDTH   = 3;
    localparam int c_OR1200_TSCHED_QUANTUM = 1;
    localparam int c_QCNT_W                = 4;

    typedef enum logic [1:0] {
        TSTATE_DIS  = 2'd0,
        TSTATE_RDY  = 2'd1,
        TSTATE_WAIT = 2'd2,
        TSTATE_EXC  = 2'd3
    } tstate_e;

endpackage
`default_nettype wire

// File: rtl/or1200_thread_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_thread_sched_if
//  Purpose  : Event inputs and grant outputs of the per-cycle thread scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface or1200_thread_sched_if
    import or1200_thread_sched_pkg::*;
#(
    parameter int NTHREADS = c_OR1200_NTHREADS,
    parameter int TID_W    = c_OR1200_THREAD_WIDTH
);

    logic [NTHREADS-1:0] thread_en;
    logic                wait_set;
    logic [TID_W-1:0]    wait_set_tid;
    logic                wait_clr;
    logic [TID_W-1:0]    wait_clr_tid;
    logic                except_start;
    logic [TID_W-1:0]    except_thread;
    logic                genpc_freeze;
    logic                sched_valid;
    logic [TID_W-1:0]    sched_thread;
    logic                sched_except;
    logic [NTHREADS-1:0] thread_busy;

    modport master (
        output thread_en, wait_set, wait_set_tid, wait_clr, wait_clr_tid,
               except_start, except_thread, genpc_freeze,
        input  sched_valid, sched_thread, sched_except, thread_busy
    );

    modport slave (
        input  thread_en, wait_set, wait_set_tid, wait_clr, wait_clr_tid,
               except_start, except_thread, genpc_freeze,
        output sched_valid, sched_thread, sched_except, thread_busy
    );

endinterface
`default_nettype wire

// File: rtl/or1200_thread_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_thread_rr_pick
//  Purpose  : Rotating-priority finder: first set request at or after start.
//  Revision : 1.0 - initial release
// ============================================================================
module or1200_thread_rr_pick
    import or1200_thread_sched_pkg::*;
#(
    parameter int NTHREADS = c_OR1200_NTHREADS,
    parameter int TID_W    = c_OR1200_THREAD_WIDTH
) (
    input  wire logic [NTHREADS-1:0] i_req,
    input  wire logic [TID_W-1:0]    i_start,
    output logic                     o_found,
    output logic [TID_W-1:0]         o_index
);

    logic [TID_W-1:0] w_idx;

    // Scan farthest-to-nearest so the closest request is written last;
    // the index wraps naturally because NTHREADS is a power of two.
    always_comb begin
        o_found = 1'b0;
        o_index = i_start;
        w_idx   = '0;
        for (int i = NTHREADS - 1; i >= 0; i--) begin
            w_idx = i_start + TID_W'(i);
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/or1200_thread_sched.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_thread_sched
//  Purpose  : Per-cycle hardware-thread scheduler feeding or1200_genpc.
//  Revision : 1.0 - initial release
// ============================================================================
module or1200_thread_sched
    import or1200_thread_sched_pkg::*;
#(
    parameter int NTHREADS = c_OR1200_NTHREADS,
    parameter int TID_W    = c_OR1200_THREAD_WIDTH,
    parameter int QUANTUM  = c_OR1200_TSCHED_QUANTUM
) (
    input  wire logic            clk,
    input  wire logic            rst,
    or1200_thread_sched_if.slave bus
);

    localparam logic [c_QCNT_W-1:0] c_QLIMIT = c_QCNT_W'(QUANTUM - 1);

    tstate_e             r_state     [NTHREADS];
    tstate_e             w_state_nxt [NTHREADS];
    logic [NTHREADS-1:0] w_exc_req;
    logic [NTHREADS-1:0] w_rdy_req;
    logic                w_exc_found;
    logic [TID_W-1:0]    w_exc_idx;
    logic                w_rdy_found;
    logic [TID_W-1:0]    w_rdy_idx;
    logic [TID_W-1:0]    w_rr_start;

    logic [TID_W-1:0]    r_rr,     w_rr_nxt;
    logic [c_QCNT_W-1:0] r_qcnt,   w_qcnt_nxt;
    logic                r_valid,  w_valid_nxt;
    logic [TID_W-1:0]    r_thread, w_thread_nxt;
    logic                r_except, w_except_nxt;
    logic [NTHREADS-1:0] r_busy,   w_busy_nxt;
    logic                w_hold;
    logic                w_exc_take;

    always_comb begin
        w_exc_req = '0;
        w_rdy_req = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            w_exc_req[t] = (r_state[t] == TSTATE_EXC);
            w_rdy_req[t] = (r_state[t] == TSTATE_RDY);
        end
    end

    assign w_rr_start = r_rr + TID_W'(1);

    or1200_thread_rr_pick #(
        .NTHREADS (NTHREADS),
        .TID_W    (TID_W)
    ) u_exc_pick (
        .i_req   (w_exc_req),
        .i_start ('0),
        .o_found (w_exc_found),
        .o_index (w_exc_idx)
    );

    or1200_thread_rr_pick #(
        .NTHREADS (NTHREADS),
        .TID_W    (TID_W)
    ) u_rdy_pick (
        .i_req   (w_rdy_req),
        .i_start (w_rr_start),
        .o_found (w_rdy_found),
        .o_index (w_rdy_idx)
    );

    // Grant selection. Exception grants leave the rotation untouched so
    // normal round-robin resumes where it left off.
    always_comb begin
        w_valid_nxt  = r_valid;
        w_thread_nxt = r_thread;
        w_except_nxt = r_except;
        w_rr_nxt     = r_rr;
        w_qcnt_nxt   = r_qcnt;
        w_exc_take   = 1'b0;
        w_hold       = r_valid && !r_except &&
                       (r_state[r_rr] == TSTATE_RDY) && (r_qcnt < c_QLIMIT);
        if (!bus.genpc_freeze) begin
            if (w_exc_found) begin
                w_valid_nxt  = 1'b1;
                w_thread_nxt = w_exc_idx;
                w_except_nxt = 1'b1;
                w_exc_take   = 1'b1;
            end else if (w_hold) begin
                w_valid_nxt  = 1'b1;
                w_thread_nxt = r_rr;
                w_except_nxt = 1'b0;
                w_qcnt_nxt   = r_qcnt + c_QCNT_W'(1);
            end else if (w_rdy_found) begin
                w_valid_nxt  = 1'b1;
                w_thread_nxt = w_rdy_idx;
                w_except_nxt = 1'b0;
                w_rr_nxt     = w_rdy_idx;
                w_qcnt_nxt   = '0;
            end else begin
                w_valid_nxt  = 1'b0;
            end
        end
    end

    // Per-thread next state, highest-priority event first. wait_set is
    // checked before wait_clr so a same-cycle set/clear leaves it waiting.
    always_comb begin
        w_busy_nxt = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            if (!bus.thread_en[t]) begin
                w_state_nxt[t] = TSTATE_DIS;
            end else if (bus.except_start && (bus.except_thread == TID_W'(t))) begin
                w_state_nxt[t] = TSTATE_EXC;
            end else if (r_state[t] == TSTATE_EXC) begin
                if (w_exc_take && (w_exc_idx == TID_W'(t))) begin
                    w_state_nxt[t] = TSTATE_RDY;
                end
            end else if (bus.wait_set && (bus.wait_set_tid == TID_W'(t)) &&
                         (r_state[t] != TSTATE_DIS)) begin
                w_state_nxt[t] = TSTATE_WAIT;
            end else if (bus.wait_clr && (bus.wait_clr_tid == TID_W'(t)) &&
                         (r_state[t] == TSTATE_WAIT)) begin
                w_state_nxt[t] = TSTATE_RDY;
            end else if (r_state[t] == TSTATE_DIS) begin
                w_state_nxt[t] = TSTATE_RDY;
            end
            w_busy_nxt[t] = (w_state_nxt[t] != TSTATE_DIS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_state[t] <= TSTATE_DIS;
            end
            r_rr     <= TID_W'(NTHREADS - 1);
            r_qcnt   <= '0;
            r_valid  <= 1'b0;
            r_thread <= '0;
            r_except <= 1'b0;
            r_busy   <= '0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_state[t] <= w_state_nxt[t];
            end
            r_rr     <= w_rr_nxt;
            r_qcnt   <= w_qcnt_nxt;
            r_valid  <= w_valid_nxt;
            r_thread <= w_thread_nxt;
            r_except <= w_except_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign bus.sched_valid  = r_valid;
    assign bus.sched_thread = r_thread;
    assign bus.sched_except = r_except;
    assign bus.thread_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_or1200_thread_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_or1200_thread_sched
//  Purpose  : Directed bench for the thread scheduler (QUANTUM 1 and 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_or1200_thread_sched;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    or1200_thread_sched_if #(.NTHREADS(8), .TID_W(3)) bus  ();
    or1200_thread_sched_if #(.NTHREADS(8), .TID_W(3)) bus3 ();

    or1200_thread_sched #(.NTHREADS(8), .TID_W(3), .QUANTUM(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    or1200_thread_sched #(.NTHREADS(8), .TID_W(3), .QUANTUM(3)) dut_q3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grant(input string tag, input int thr, input logic exc);
        tick();
        chk({tag, "_valid"}, 32'(bus.sched_valid), 32'd1);
        chk({tag, "_thread"}, 32'(bus.sched_thread), 32'(thr));
        chk({tag, "_except"}, 32'(bus.sched_except), 32'(exc));
    endtask

    task automatic grant_q3(input string tag, input int thr);
        tick();
        chk({tag, "_valid"}, 32'(bus3.sched_valid), 32'd1);
        chk({tag, "_thread"}, 32'(bus3.sched_thread), 32'(thr));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.thread_en     = 8'h00;  bus3.thread_en     = 8'h00;
        bus.wait_set      = 1'b0;   bus3.wait_set      = 1'b0;
        bus.wait_set_tid  = 3'd0;   bus3.wait_set_tid  = 3'd0;
        bus.wait_clr      = 1'b0;   bus3.wait_clr      = 1'b0;
        bus.wait_clr_tid  = 3'd0;   bus3.wait_clr_tid  = 3'd0;
        bus.except_start  = 1'b0;   bus3.except_start  = 1'b0;
        bus.except_thread = 3'd0;   bus3.except_thread = 3'd0;
        bus.genpc_freeze  = 1'b0;   bus3.genpc_freeze  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid",  32'(bus.sched_valid),  32'd0);
        chk("rst_thread", 32'(bus.sched_thread), 32'd0);
        chk("rst_except", 32'(bus.sched_except), 32'd0);
        chk("rst_busy",   32'(bus.thread_busy),  32'h00);
        rst = 1'b0;
        tick();
        chk("en0_valid", 32'(bus.sched_valid), 32'd0);
        chk("en0_busy",  32'(bus.thread_busy), 32'h00);

        // Two enabled threads alternate
        bus.thread_en = 8'h05;
        tick();
        chk("en5_busy",  32'(bus.thread_busy), 32'h05);
        chk("en5_valid", 32'(bus.sched_valid), 32'd0);
        grant("alt_a", 0, 1'b0);
        grant("alt_b", 2, 1'b0);
        grant("alt_c", 0, 1'b0);
        grant("alt_d", 2, 1'b0);

        // Full rotation with wrap
        bus.thread_en = 8'hFF;
        grant("rot_first", 0, 1'b0);
        chk("rot_busy", 32'(bus.thread_busy), 32'hFF);
        for (int i = 1; i <= 8; i++) begin
            grant("rot", i % 8, 1'b0);
        end

        // Thread 3 parked and released
        bus.wait_set = 1'b1; bus.wait_set_tid = 3'd3;
        grant("ws_1", 1, 1'b0);
        bus.wait_set = 1'b0;
        grant("ws_2", 2, 1'b0);
        grant("skip3", 4, 1'b0);
        chk("wait_busy", 32'(bus.thread_busy), 32'hFF);
        grant("ws_5", 5, 1'b0);
        grant("ws_6", 6, 1'b0);
        grant("ws_7", 7, 1'b0);
        grant("ws_0", 0, 1'b0);
        grant("ws_1b", 1, 1'b0);
        grant("ws_2b", 2, 1'b0);
        bus.wait_clr = 1'b1; bus.wait_clr_tid = 3'd3;
        grant("wc_4", 4, 1'b0);
        bus.wait_clr = 1'b0;
        grant("wc_5", 5, 1'b0);
        grant("wc_6", 6, 1'b0);
        grant("wc_7", 7, 1'b0);
        grant("wc_0", 0, 1'b0);
        grant("wc_1", 1, 1'b0);
        grant("wc_2", 2, 1'b0);
        grant("back3", 3, 1'b0);

        // Same-cycle set and clear: set wins
        bus.wait_set = 1'b1; bus.wait_set_tid = 3'd5;
        bus.wait_clr = 1'b1; bus.wait_clr_tid = 3'd5;
        grant("sc_4", 4, 1'b0);
        bus.wait_set = 1'b0;
        bus.wait_clr = 1'b0;
        grant("set_wins", 6, 1'b0);
        grant("sc_7", 7, 1'b0);

        // Exception on a waiting thread
        bus.except_start = 1'b1; bus.except_thread = 3'd5;
        grant("ex_0", 0, 1'b0);
        bus.except_start = 1'b0;
        grant("exc5", 5, 1'b1);
        grant("ex_1", 1, 1'b0);
        grant("ex_2", 2, 1'b0);
        grant("ex_3", 3, 1'b0);
        grant("ex_4", 4, 1'b0);
        grant("exc5_rdy", 5, 1'b0);

        // Freeze with coincident events
        bus.genpc_freeze  = 1'b1;
        bus.wait_set      = 1'b1; bus.wait_set_tid  = 3'd1;
        bus.except_start  = 1'b1; bus.except_thread = 3'd6;
        grant("frz_1", 5, 1'b0);
        bus.wait_set     = 1'b0;
        bus.except_start = 1'b0;
        grant("frz_2", 5, 1'b0);
        grant("frz_3", 5, 1'b0);
        chk("frz_busy", 32'(bus.thread_busy), 32'hFF);
        bus.genpc_freeze = 1'b0;
        grant("unfrz_exc6", 6, 1'b1);
        grant("uf_6", 6, 1'b0);
        grant("uf_7", 7, 1'b0);
        grant("uf_0", 0, 1'b0);
        grant("skip1", 2, 1'b0);

        // Disable the holder, then reset mid-rotation
        bus.thread_en = 8'hFB;
        grant("dis_3", 3, 1'b0);
        chk("dis_busy", 32'(bus.thread_busy), 32'hFB);
        grant("dis_4", 4, 1'b0);
        grant("dis_5", 5, 1'b0);
        grant("dis_6", 6, 1'b0);
        grant("dis_7", 7, 1'b0);
        grant("dis_0", 0, 1'b0);
        grant("skip2", 3, 1'b0);
        rst = 1'b1;
        tick();
        chk("mrst_valid",  32'(bus.sched_valid),  32'd0);
        chk("mrst_thread", 32'(bus.sched_thread), 32'd0);
        chk("mrst_except", 32'(bus.sched_except), 32'd0);
        chk("mrst_busy",   32'(bus.thread_busy),  32'h00);

        // Post-reset restart, plus QUANTUM=3 instance
        rst = 1'b0;
        bus.thread_en  = 8'hFF;
        bus3.thread_en = 8'hFF;
        tick();
        chk("post_valid",    32'(bus.sched_valid),  32'd0);
        chk("post_q3_valid", 32'(bus3.sched_valid), 32'd0);
        chk("post_busy",     32'(bus.thread_busy),  32'hFF);
        tick();
        chk("post_thread",   32'(bus.sched_thread), 32'd0);
        chk("post_vld1",     32'(bus.sched_valid),  32'd1);
        chk("q3_first",      32'(bus3.sched_thread), 32'd0);
        grant_q3("q3_0b", 0);
        grant_q3("q3_0c", 0);
        grant_q3("q3_1a", 1);
        grant_q3("q3_1b", 1);
        grant_q3("q3_1c", 1);
        grant_q3("q3_2a", 2);
        grant_q3("q3_2b", 2);
        grant_q3("q3_2c", 2);
        grant_q3("q3_3a", 3);
        bus3.wait_set = 1'b1; bus3.wait_set_tid = 3'd3;
        grant_q3("q3_3b", 3);
        bus3.wait_set = 1'b0;
        grant_q3("q3_held_wait", 4);
        grant_q3("q3_4b", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or1200_thread_sched.md
Name: or1200_thread_sched

Overview:
- Per-cycle thread scheduler that sits in front of or1200_genpc in the multithreaded OR1200 core.
- Tracks the run state of each hardware thread: disabled, ready, waiting or exception-pending.
- Each unfrozen cycle it picks the thread whose PC genpc fetches next.
- Exception-pending threads take priority. Ready threads share fetch round-robin, with an optional quantum of consecutive cycles per thread.

Parameters:
- NTHREADS, 8, number of hardware threads (power of two).
- TID_W, 3, thread-id width, log2(NTHREADS).
- QUANTUM, 1, max consecutive grants to one ready thread before rotating (1 = fine-grained interleave, range 1..15).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset, sampled on rising clk.
- thread_en  in  NTHREADS  per-thread enable from SPR; level-sensitive.
- wait_set  in  1  stall a thread (icpu_rty_i/icache miss), id on wait_set_tid.
- wait_set_tid  in  TID_W  thread to stall.
- wait_clr  in  1  release a stalled thread, id on wait_clr_tid.
- wait_clr_tid  in  TID_W  thread to release.
- except_start  in  1  exception raised for except_thread.
- except_thread  in  TID_W  faulting thread.
- genpc_freeze  in  1  pipeline freeze; scheduler holds its grant.
- sched_valid  out  1  a thread is granted this cycle.
- sched_thread  out  TID_W  granted thread id, to genpc branch/fetch thread select.
- sched_except  out  1  granted thread must fetch its exception vector.
- thread_busy  out  NTHREADS  1 where thread state != DIS (SPR status readback).

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high (clk, rst).
- State on reset:
  - All per-thread states go to DIS.
  - sched_valid=0, sched_thread=0, sched_except=0, thread_busy=0.
  - rr pointer (last granted id) = NTHREADS-1, so the first rotation starts at thread 0.
  - Quantum counter = 0.
- A reset asserted mid-operation overrides all other inputs in that cycle.
- Per-thread state: 2 bits; DIS=0, RDY=1, WAIT=2, EXC=3.
- State transitions, priority high to low, evaluated per thread t:
  1. thread_en[t]=0 -> DIS, whatever other events occur.
  2. except_start & except_thread==t -> EXC. This overrides WAIT and coincident wait_set/wait_clr.
  3. EXC, granted with sched_except this cycle and not frozen -> RDY.
  4. wait_set & wait_set_tid==t, from RDY -> WAIT. If wait_clr names the same thread in the same cycle, set wins.
  5. wait_clr & wait_clr_tid==t, from WAIT -> RDY. wait_clr on a non-WAIT thread is ignored.
  6. DIS & thread_en[t]=1 -> RDY.
- Selection (combinational from current state), registered into outputs on the next clk; one cycle latency from a state change to grant visibility:
  - If any EXC thread exists: grant the lowest-index EXC thread with sched_except=1. The rr pointer and quantum counter are not updated.
  - Else if the current holder is still RDY and qcnt < QUANTUM-1: re-grant the holder and increment qcnt.
  - Else: grant the first RDY thread searching from rr+1 with wrap-around (NTHREADS-1 -> 0). Set rr to that thread and clear qcnt.
  - Else (no RDY thread): sched_valid=0. Outputs sched_thread/sched_except keep their last values; rr and qcnt are held.
- A granted thread that enters WAIT or DIS loses its grant on the next cycle; the next eligible thread is selected with no bubble.
- genpc_freeze=1:
  - sched_* outputs, rr and qcnt hold.
  - Per-thread state transitions 1, 2, 4, 5 and 6 still apply; transition 3 (EXC->RDY) does not.
  - The first unfrozen cycle selects from the updated states.
- thread_busy is registered from the next-state value, so it has the same timing as sched_*.

Decomposition:
- Shared defines in or1200_defines.v:
  - OR1200_THREAD_WIDTH (3), OR1200_NTHREADS (8).
  - State encodings OR1200_TSTATE_DIS/RDY/WAIT/EXC.
  - OR1200_TSCHED_QUANTUM default.
- Sub-module or1200_thread_rr_pick: combinational rotating priority finder. Inputs are a request vector and a start index. Outputs are found (1 bit) and index (TID_W). It is instantiated twice:
  - once with start 0 for the EXC search (fixed priority);
  - once with start rr+1 for the RDY search.

Test Plan:
- Reset, then thread_en=8'h00 -> sched_valid=0, thread_busy=0. Raise thread_en=8'h05 -> over the following cycles sched_thread alternates 0,2,0,2 with sched_valid=1.
- thread_en=8'hFF with QUANTUM=1 -> grants run 0..7 and wrap to 0. Repeat with QUANTUM=3 -> 0,0,0,1,1,1,2,...
- All threads RDY; wait_set with tid=3 -> thread 3 is skipped (…2,4…). wait_clr with tid=3 -> thread 3 reappears in rotation. Same-cycle wait_set and wait_clr with tid=5 -> thread 5 ends in WAIT.
- except_start with except_thread=5 while thread 5 is in WAIT -> next grant is sched_thread=5 with sched_except=1, then thread 5 returns to RDY and rotation resumes from the previous rr.
- genpc_freeze held 3 cycles while wait_set tid=1 and except_start thread=6 arrive -> outputs frozen throughout. First unfrozen grant is 6 with sched_except=1, and thread 1 is skipped afterwards.
- Drop thread_en[2] while thread 2 holds the grant, then assert rst mid-rotation -> thread 2 goes to DIS and the grant moves on the next cycle. After rst, all outputs are 0 and all states DIS.
